rega_sequenciador: RTL



---
 rtl/rega_sequenciador_pkg.sv | 30 +++
 rtl/rega_sequenciador_cont_bcd_dec.sv | 45 ++++
 rtl/rega_sequenciador.sv | 125 ++++++++++++
 3 files changed

// File: rtl/rega_sequenciador_pkg.sv
// Shared definitions for the irrigation sequencer: state encoding, tank level
// constant and the parameter-to-BCD conversion used for phase loads.
package rega_sequenciador_pkg;

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        LIMPEZA = 3'd1,
        MISTURA = 3'd2,
        REGA    = 3'd3,
        ALARME  = 3'd4
    } estado_t;

    localparam logic [1:0] NV_VAZIO = 2'b00;

    typedef struct packed {
        logic [1:0] dez;
        logic [3:0] un;
    } bcd2_t;

    // Out-of-range durations are clamped to 39; zero behaves as one.
    function automatic bcd2_t bin2bcd(input int unsigned v);
        int unsigned c;
        bcd2_t       r;
        c     = (v > 39) ? 39 : ((v == 0) ? 1 : v);
        r.dez = 2'(c / 10);
        r.un  = 4'(c % 10);
        return r;
    endfunction

endpackage

// File: rtl/rega_sequenciador_cont_bcd_dec.sv
// Two-digit BCD down-counter with clear, load and enable (priority in that
// order), asynchronous active-low reset and a "count equals 01" flag.
module cont_bcd_dec
    import rega_sequenciador_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_ni,
    input  logic  clr_i,
    input  logic  load_i,
    input  bcd2_t load_val_i,
    input  logic  en_i,
    output bcd2_t cont_o,
    output logic  eq_um_o
);

    bcd2_t cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            if (cnt_q.un == 4'd0) begin
                cnt_d.un  = 4'd9;
                cnt_d.dez = cnt_q.dez - 2'd1;
            end else begin
                cnt_d.un  = cnt_q.un - 4'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cont_o  = cnt_q;
    assign eq_um_o = (cnt_q.dez == 2'd0) && (cnt_q.un == 4'd1);

endmodule

// File: rtl/rega_sequenciador.sv
// Watering-cycle sequencer: cleaning -> mixing -> watering with a BCD
// countdown of the remaining phase time and an empty-tank alarm.
module rega_sequenciador
    import rega_sequenciador_pkg::*;
#(
    parameter int unsigned T_LIMP = 5,
    parameter int unsigned T_MIST = 10,
    parameter int unsigned T_REGA = 30
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       Tick,
    input  logic       Start,
    input  logic       Nv1,
    input  logic       Nv0,
    output logic       Limp,
    output logic       Mist,
    output logic       Valvula,
    output logic       Alarme,
    output logic [3:0] ContA,
    output logic [1:0] ContB
);

    localparam bcd2_t BCD_LIMP = bin2bcd(T_LIMP);
    localparam bcd2_t BCD_MIST = bin2bcd(T_MIST);
    localparam bcd2_t BCD_REGA = bin2bcd(T_REGA);

    estado_t state_q, state_d;
    logic    limp_q, mist_q, valv_q, alarm_q;
    logic    cnt_clr, cnt_load, cnt_en, eq_um;
    bcd2_t   cnt_val, cont;
    logic    vazio;

    assign vazio = ({Nv1, Nv0} == NV_VAZIO);

    // Level check outranks Tick; a Tick on the count=01 edge moves to the
    // next phase instead of decrementing, so 00 is never shown while active.
    always_comb begin
        state_d  = state_q;
        cnt_clr  = 1'b0;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        cnt_val  = BCD_LIMP;
        unique case (state_q)
            OCIOSO: begin
                if (Start) begin
                    if (vazio) begin
                        state_d = ALARME;
                        cnt_clr = 1'b1;
                    end else begin
                        state_d  = LIMPEZA;
                        cnt_load = 1'b1;
                    end
                end
            end
            LIMPEZA, MISTURA, REGA: begin
                if (vazio) begin
                    state_d = ALARME;
                    cnt_clr = 1'b1;
                end else if (Tick) begin
                    if (eq_um) begin
                        if (state_q == LIMPEZA) begin
                            state_d  = MISTURA;
                            cnt_load = 1'b1;
                            cnt_val  = BCD_MIST;
                        end else if (state_q == MISTURA) begin
                            state_d  = REGA;
                            cnt_load = 1'b1;
                            cnt_val  = BCD_REGA;
                        end else begin
                            state_d = OCIOSO;
                            cnt_clr = 1'b1;
                        end
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
            end
            ALARME: begin
                if (!vazio) begin
                    state_d = OCIOSO;
                end
            end
            default: begin
                state_d = OCIOSO;
                cnt_clr = 1'b1;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= OCIOSO;
            limp_q  <= 1'b0;
            mist_q  <= 1'b0;
            valv_q  <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            limp_q  <= (state_d == LIMPEZA);
            mist_q  <= (state_d == MISTURA);
            valv_q  <= (state_d == REGA);
            alarm_q <= (state_d == ALARME);
        end
    end

    cont_bcd_dec u_cont (
        .clk_i      (Clk),
        .rst_ni     (Reset_n),
        .clr_i      (cnt_clr),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .en_i       (cnt_en),
        .cont_o     (cont),
        .eq_um_o    (eq_um)
    );

    assign Limp    = limp_q;
    assign Mist    = mist_q;
    assign Valvula = valv_q;
    assign Alarme  = alarm_q;
    assign ContA   = cont.un;
    assign ContB   = cont.dez;

endmodule
